dsp_sequencer: RTL and testbench

Per-sample-period instruction sequencer for dsp_core. On each sample_tick it runs the stored program once: it fetches addresses 0..prog_last from a double-banked program memory and presents one instruction per cycle on dsp_core's instruction input. It then issues NOPs while the core pipeline drains and signals frame completion. It also handles glitch-free host bank swaps at frame boundaries and flags sample-rate overruns.

---
 rtl/dsp_pkg.sv | 31 +++
 rtl/dsp_sequencer.sv | 122 ++++++++++++
 tb/tb_dsp_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared types and constants for dsp_core and its instruction sequencer.
package dsp_pkg;

    localparam int INSTR_WIDTH     = 26;
    localparam int PROG_ADDR_WIDTH = 10;
    localparam int PIPE_DEPTH      = 5;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_LOAD = 6'h01,
        OP_MUL  = 6'h02,
        OP_MAC  = 6'h03,
        OP_ADD  = 6'h04,
        OP_STORE = 6'h05
    } opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [9:0] smp_addr;
        logic [9:0] par_addr;
    } instr_t;

    localparam instr_t NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/dsp_sequencer.sv
// Per-sample-period program sequencer: fetches the active bank once per
// sample_tick, drains the dsp_core pipeline and handles bank swaps.
module dsp_sequencer #(
    parameter int INSTR_WIDTH     = dsp_pkg::INSTR_WIDTH,
    parameter int PROG_ADDR_WIDTH = dsp_pkg::PROG_ADDR_WIDTH,
    parameter int PIPE_DEPTH      = dsp_pkg::PIPE_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic [PROG_ADDR_WIDTH-1:0] prog_last,
    input  logic                       bank_swap_req,
    input  logic                       overrun_clr,
    output logic                       prog_rd_en,
    output logic [PROG_ADDR_WIDTH:0]   prog_rd_addr,
    input  logic [INSTR_WIDTH-1:0]     prog_rd_data,
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       active_bank,
    output logic                       bank_swap_ack,
    output logic                       overrun
);

    import dsp_pkg::*;

    localparam int DW = $clog2(PIPE_DEPTH + 1);

    seq_state_t                 state_q;
    seq_state_t                 state_d;
    logic [PROG_ADDR_WIDTH-1:0] pc_q;
    logic [PROG_ADDR_WIDTH-1:0] last_q;
    logic [DW-1:0]              drain_q;
    logic                       issue_valid_q;
    logic                       bank_q;
    logic                       pending_q;
    logic                       ack_q;
    logic                       overrun_q;

    logic final_drain;
    logic tick_accept;
    logic run_end;
    logic do_swap;

    assign final_drain = (state_q == DRAIN) && (drain_q == '0);
    assign tick_accept = sample_tick && ((state_q == IDLE) || final_drain);
    assign run_end     = (state_q == RUN) && (pc_q == last_q);
    assign do_swap     = tick_accept && (pending_q || bank_swap_req);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_tick) state_d = RUN;
            RUN:     if (pc_q == last_q) state_d = DRAIN;
            DRAIN: begin
                if (drain_q == '0)
                    state_d = sample_tick ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            last_q        <= '0;
            drain_q       <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= prog_rd_en;
            if (tick_accept) begin
                pc_q   <= '0;
                last_q <= prog_last;
            end else if ((state_q == RUN) && !run_end) begin
                pc_q <= pc_q + PROG_ADDR_WIDTH'(1);
            end
            if (run_end)
                drain_q <= DW'(PIPE_DEPTH);
            else if ((state_q == DRAIN) && (drain_q != '0))
                drain_q <= drain_q - DW'(1);
        end
    end

    // Swaps are deferred to a frame start so a frame never mixes banks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q    <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= do_swap;
            if (do_swap) begin
                bank_q    <= ~bank_q;
                pending_q <= 1'b0;
            end else if (bank_swap_req) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun_q <= 1'b0;
        else if (sample_tick && (state_q != IDLE) && !final_drain)
            overrun_q <= 1'b1;
        else if (overrun_clr)
            overrun_q <= 1'b0;
    end

    assign prog_rd_en    = (state_q == RUN);
    assign prog_rd_addr  = {bank_q, pc_q};
    assign instruction   = issue_valid_q ? prog_rd_data
                                         : INSTR_WIDTH'(NOP_INSTR);
    assign busy          = (state_q != IDLE);
    assign frame_done    = final_drain;
    assign active_bank   = bank_q;
    assign bank_swap_ack = ack_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer with a registered-read program memory.
module tb_dsp_sequencer;

    localparam int IW = 26;
    localparam int AW = 10;
    localparam int PD = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sample_tick;
    logic [AW-1:0] prog_last;
    logic          bank_swap_req;
    logic          overrun_clr;
    logic          prog_rd_en;
    logic [AW:0]   prog_rd_addr;
    logic [IW-1:0] prog_rd_data;
    logic [IW-1:0] instruction;
    logic          busy;
    logic          frame_done;
    logic          active_bank;
    logic          bank_swap_ack;
    logic          overrun;

    logic [IW-1:0] mem [0:(1<<(AW+1))-1];

    int n_tests = 0;
    int n_fail  = 0;

    dsp_sequencer #(
        .INSTR_WIDTH    (IW),
        .PROG_ADDR_WIDTH(AW),
        .PIPE_DEPTH     (PD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .prog_last    (prog_last),
        .bank_swap_req(bank_swap_req),
        .overrun_clr  (overrun_clr),
        .prog_rd_en   (prog_rd_en),
        .prog_rd_addr (prog_rd_addr),
        .prog_rd_data (prog_rd_data),
        .instruction  (instruction),
        .busy         (busy),
        .frame_done   (frame_done),
        .active_bank  (active_bank),
        .bank_swap_ack(bank_swap_ack),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (prog_rd_en) prog_rd_data <= mem[prog_rd_addr];

    function automatic logic [31:0] val(input logic bank, input int i);
        return bank ? 32'h200_0000 + 32'(i) + 1 : 32'(i) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 40) begin
            step();
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Tick at T0; checks every output cycle by cycle until back in IDLE.
    task automatic run_frame(input int last, input logic bank);
        int   n;
        logic en_e;
        logic [31:0] ins_e;
        n = last + PD + 4;
        prog_last   = AW'(last);
        sample_tick = 1'b1;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            en_e  = (t >= 1) && (t <= last + 1);
            ins_e = (t >= 2 && t <= last + 2) ? val(bank, t - 2) : 32'd0;
            chk("rd_en", 32'(prog_rd_en), 32'(en_e));
            if (en_e)
                chk("rd_addr", 32'(prog_rd_addr),
                    32'({bank, AW'(t - 1)}));
            chk("instr", 32'(instruction), ins_e);
            chk("busy", 32'(busy), 32'(t >= 1 && t <= last + PD + 2));
            chk("done", 32'(frame_done), 32'(t == last + PD + 2));
            chk("bank", 32'(active_bank), 32'(bank));
            step();
            sample_tick = 1'b0;
            if (t == 1) prog_last = ~AW'(last);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]             = IW'(val(1'b0, i));
            mem[(1 << AW) + i] = IW'(val(1'b1, i));
        end
        reset_n       = 1'b0;
        sample_tick   = 1'b0;
        prog_last     = '0;
        bank_swap_req = 1'b0;
        overrun_clr   = 1'b0;
        repeat (2) step();
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(prog_rd_en), 32'd0);
        chk("rst_bank", 32'(active_bank), 32'd0);
        chk("rst_ack", 32'(bank_swap_ack), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        run_frame(3, 1'b0);
        run_frame(0, 1'b0);
        run_frame(6, 1'b0);
        run_frame((1 << AW) - 1, 1'b0);

        // Overrun: second tick in non-final DRAIN, then clear.
        prog_last   = 3;
        sample_tick = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t == 6)  chk("ovr_pre", 32'(overrun), 32'd0);
            if (t == 7)  chk("ovr_set", 32'(overrun), 32'd1);
            if (t == 10) chk("ovr_done", 32'(frame_done), 32'd1);
            if (t == 11) chk("ovr_idle", 32'(busy), 32'd0);
            if (t == 12) chk("ovr_hold", 32'(overrun), 32'd1);
            if (t == 13) chk("ovr_clr", 32'(overrun), 32'd0);
            step();
            sample_tick = (t + 1 == 6);
            overrun_clr = (t + 1 == 12);
        end
        overrun_clr = 1'b0;

        // Set and clear in the same cycle: set wins.
        sample_tick = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (t == 3) chk("ovr_setwin", 32'(overrun), 32'd1);
            step();
            sample_tick = (t + 1 == 2);
            overrun_clr = (t + 1 == 2);
        end
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        wait_idle("ovr2_end");
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr2", 32'(overrun), 32'd0);

        // Back-to-back frames: tick in the final DRAIN cycle.
        prog_last   = 3;
        sample_tick = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t == 10) chk("b2b_done", 32'(frame_done), 32'd1);
            if (t == 11) begin
                chk("b2b_busy", 32'(busy), 32'd1);
                chk("b2b_en", 32'(prog_rd_en), 32'd1);
                chk("b2b_addr", 32'(prog_rd_addr), 32'd0);
                chk("b2b_ovr", 32'(overrun), 32'd0);
            end
            if (t == 12) chk("b2b_ins0", 32'(instruction), 32'd1);
            if (t == 13) chk("b2b_ins1", 32'(instruction), 32'd2);
            step();
            sample_tick = (t + 1 == 10);
        end
        wait_idle("b2b_end");
        chk("b2b_ovr_end", 32'(overrun), 32'd0);

        // Bank swap requested mid-frame applies at the next frame start.
        prog_last   = 3;
        sample_tick = 1'b1;
        for (int t = 0; t < 23; t++) begin
            @(negedge clk);
            if (t == 5 || t == 19) begin
                chk("swp_bank0", 32'(active_bank), 32'd0);
                chk("swp_noack", 32'(bank_swap_ack), 32'd0);
            end
            if (t == 21) begin
                chk("swp_bank1", 32'(active_bank), 32'd1);
                chk("swp_ack", 32'(bank_swap_ack), 32'd1);
                chk("swp_addr", 32'(prog_rd_addr), 32'h400);
            end
            if (t == 22) begin
                chk("swp_ack_off", 32'(bank_swap_ack), 32'd0);
                chk("swp_ins", 32'(instruction), val(1'b1, 0));
            end
            step();
            sample_tick   = (t + 1 == 20);
            bank_swap_req = (t + 1 == 3 || t + 1 == 4);
        end
        wait_idle("swp_end");
        run_frame(2, 1'b1);

        // Request coinciding with the accepted tick swaps at that frame.
        prog_last     = 1;
        sample_tick   = 1'b1;
        bank_swap_req = 1'b1;
        step();
        sample_tick   = 1'b0;
        bank_swap_req = 1'b0;
        @(negedge clk);
        chk("swp_same_bank", 32'(active_bank), 32'd0);
        chk("swp_same_ack", 32'(bank_swap_ack), 32'd1);
        chk("swp_same_addr", 32'(prog_rd_addr), 32'h000);
        step();
        wait_idle("swp_same_end");

        // Async reset mid-RUN on bank 1, then restart from bank 0 addr 0.
        prog_last     = 7;
        sample_tick   = 1'b1;
        bank_swap_req = 1'b1;
        step();
        sample_tick   = 1'b0;
        bank_swap_req = 1'b0;
        step();
        step();
        chk("pre_rst_en", 32'(prog_rd_en), 32'd1);
        chk("pre_rst_bank", 32'(active_bank), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_instr", 32'(instruction), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_en", 32'(prog_rd_en), 32'd0);
        chk("arst_bank", 32'(active_bank), 32'd0);
        step();
        #2;
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_frame(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
